// File: rtl/sensor_scheduler.sv
// sensor_scheduler: fires front/left ultrasonic sensors alternately, thresholds echo width
// into wall bits, debounces them, and strobes valid after each head+left round.
module sensor_scheduler #(
    parameter int TRIG_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int THRESH         = 200,
    parameter int DEB            = 2,
    parameter int CNT_W          = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic echo_head,
    input  logic echo_left,
    output logic trig_head,
    output logic trig_left,
    output logic head,
    output logic left,
    output logic valid,
    output logic timeout
);
    localparam int RW = $clog2(DEB + 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   width;
    logic [2:0]       sh_q, sl_q;
    logic             sel_q, sample_q, sample_d, to_d, to_q, valid_q;
    logic             trig_h_q, trig_l_q;
    logic             echo_s, echo_rise, cnt_max;
    logic [1:0]       out_q, out_d, cand_q, cand_d;
    logic [RW-1:0]    run_q [2];
    logic [RW-1:0]    run_d [2];
    logic             o, c, streak, hit;
    logic [RW-1:0]    r;

    // Bit 1 of each shift register is the synchronized echo; bit 2 is its previous value.
    assign echo_s    = sel_q ? sl_q[1] : sh_q[1];
    assign echo_rise = echo_s & ~(sel_q ? sl_q[2] : sh_q[2]);
    assign cnt_max   = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    assign width     = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        to_d     = 1'b0;
        case (state_q)
            IDLE:      if (enable) state_d = TRIG;
            TRIG:      if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) state_d = WAIT_RISE;
            WAIT_RISE: if (echo_rise) state_d = MEASURE;
                       else if (cnt_max) begin
                           sample_d = 1'b0;
                           to_d     = 1'b1;
                           state_d  = DONE;
                       end
            MEASURE:   if (!echo_s) begin
                           sample_d = width < (CNT_W + 1)'(THRESH);
                           state_d  = DONE;
                       end else if (cnt_max) begin
                           sample_d = 1'b0;
                           to_d     = 1'b1;
                           state_d  = DONE;
                       end
            DONE:      state_d = enable ? TRIG : IDLE;
            default:   state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    end

    // The run counter only ever counts consecutive samples that disagree with the output.
    assign o      = out_q[sel_q];
    assign c      = cand_q[sel_q];
    assign r      = run_q[sel_q];
    assign streak = sample_q == c;
    assign hit    = streak ? (r == RW'(DEB - 1)) : (DEB == 1);

    always_comb begin
        out_d  = out_q;
        cand_d = cand_q;
        run_d  = run_q;
        if (state_q == DONE) begin
            if (sample_q == o) run_d[sel_q] = '0;
            else begin
                cand_d[sel_q] = sample_q;
                run_d[sel_q]  = hit ? '0 : (streak ? r + 1'b1 : RW'(1));
                out_d[sel_q]  = hit ? sample_q : o;
            end
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            sl_q     <= '0;
            sel_q    <= 1'b0;
            sample_q <= 1'b0;
            out_q    <= '0;
            cand_q   <= '0;
            run_q    <= '{default: '0};
            trig_h_q <= 1'b0;
            trig_l_q <= 1'b0;
            valid_q  <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= {sh_q[1:0], echo_head};
            sl_q     <= {sl_q[1:0], echo_left};
            sel_q    <= (state_q == DONE) ? ~sel_q : sel_q;
            sample_q <= sample_d;
            out_q    <= out_d;
            cand_q   <= cand_d;
            run_q    <= run_d;
            trig_h_q <= (state_q == TRIG) && !sel_q;
            trig_l_q <= (state_q == TRIG) && sel_q;
            valid_q  <= (state_q == DONE) && sel_q;
            to_q     <= to_d;
        end
    end

    assign trig_head = trig_h_q;
    assign trig_left = trig_l_q;
    assign head      = out_q[0];
    assign left      = out_q[1];
    assign valid     = valid_q;
    assign timeout   = to_q;
endmodule

// File: tb/tb_sensor_scheduler.sv
// tb_sensor_scheduler: drives sensor echo pulses and checks head/left/valid/timeout
// against a measurement-level model of thresholding and debouncing.
module tb_sensor_scheduler;
    localparam int TRIG = 10;
    localparam int TMO  = 1000;
    localparam int TH   = 200;
    localparam int DEB  = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic echo_head = 1'b0;
    logic echo_left = 1'b0;
    logic trig_head, trig_left, head, left, valid, timeout;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_to = 0;
    bit exp_out [2];
    int streak [2];
    bit exp_sel;
    int exp_valid = 0;
    int exp_to = 0;

    sensor_scheduler #(
        .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .THRESH(TH), .DEB(DEB), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .echo_head(echo_head), .echo_left(echo_left),
        .trig_head(trig_head), .trig_left(trig_left),
        .head(head), .left(left), .valid(valid), .timeout(timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (valid) n_valid++;
        if (timeout) n_to++;
    end

    function automatic void model_reset();
        exp_out[0] = 1'b0;
        exp_out[1] = 1'b0;
        streak[0]  = 0;
        streak[1]  = 0;
        exp_sel    = 1'b0;
    endfunction

    // An output flips once DEB consecutive samples of a channel disagree with it.
    function automatic void model_apply(int w);
        bit s;
        int ch;
        s  = (w > 0) && (w < TH);
        ch = exp_sel ? 1 : 0;
        if (s != exp_out[ch]) begin
            streak[ch]++;
            if (streak[ch] == DEB) begin
                exp_out[ch] = s;
                streak[ch]  = 0;
            end
        end else streak[ch] = 0;
        if (ch == 1) exp_valid++;
        if (w == 0) exp_to++;
        exp_sel = !exp_sel;
    endfunction

    task automatic measure(input int w, input bit drop, output bit seen, output bit got_ch,
                           output int tlen, output bit got_h, output bit got_l);
        int n;
        n = 0;
        seen = 0; got_ch = 0; tlen = 0; got_h = 0; got_l = 0;
        do begin
            @(posedge clock);
            n++;
        end while (!(trig_head || trig_left) && n < 3000);
        if (!(trig_head || trig_left)) return;
        seen   = 1;
        got_ch = trig_left;
        got_h  = head;
        got_l  = left;
        if (drop) enable = 1'b0;
        while ((trig_head || trig_left) && tlen < 200) begin
            tlen++;
            @(posedge clock);
        end
        if (w == 0) return;
        repeat ($urandom_range(2, 15)) @(posedge clock);
        if (got_ch) echo_left = 1'b1; else echo_head = 1'b1;
        repeat (w) begin
            @(posedge clock);
            if (got_ch) echo_head = 1'($urandom_range(0, 1));
            else echo_left = 1'($urandom_range(0, 1));
        end
        echo_head = 1'b0;
        echo_left = 1'b0;
    endtask

    task automatic step(input string name, input int w, input bit drop);
        bit seen, ch, h, l;
        int tlen;
        measure(w, drop, seen, ch, tlen, h, l);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s trig_seen: got none within 3000 cycles, want a trigger", name);
        end else begin
            checks++;
            if (ch !== exp_sel) begin
                errors++;
                $display("FAIL %s channel: got trig_left=%0b want %0b", name, ch, exp_sel);
            end
            checks++;
            if (tlen !== TRIG) begin
                errors++;
                $display("FAIL %s trig_len: got %0d want %0d", name, tlen, TRIG);
            end
            checks++;
            if ({h, l} !== {exp_out[0], exp_out[1]}) begin
                errors++;
                $display("FAIL %s head_left: got %0b%0b want %0b%0b", name, h, l, exp_out[0], exp_out[1]);
            end
            checks++;
            if (n_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s valid_count: got %0d want %0d", name, n_valid, exp_valid);
            end
            checks++;
            if (n_to !== exp_to) begin
                errors++;
                $display("FAIL %s timeout_count: got %0d want %0d", name, n_to, exp_to);
            end
        end
        model_apply(w);
    endtask

    task automatic test_reset();
        int n, trigs;
        model_reset();
        repeat (2) @(posedge clock);
        checks++;
        if ({trig_head, trig_left, head, left, valid, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %06b want 000000",
                     {trig_head, trig_left, head, left, valid, timeout});
        end
        reset = 1'b1;
        trigs = 0;
        repeat (20) begin
            @(posedge clock);
            if (trig_head || trig_left) trigs++;
        end
        checks++;
        if (trigs !== 0) begin
            errors++;
            $display("FAIL idle_no_trig: got %0d trigger cycles want 0", trigs);
        end
        enable = 1'b1;
        n = 0;
        do begin
            @(posedge clock);
            n++;
        end while (!trig_head && n < 100);
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({trig_head, trig_left, head, left, valid, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_trig: got %06b want 000000",
                     {trig_head, trig_left, head, left, valid, timeout});
        end
        @(posedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_wall_ahead();
        int ws [4] = '{100, 500, 100, 500};
        foreach (ws[i]) step("wall_ahead", ws[i], 1'b0);
    endtask

    task automatic test_threshold();
        int ws [16] = '{199, 500, 199, 500, 200, 500, 200, 500,
                        199, 500, 199, 500, 201, 500, 201, 500};
        foreach (ws[i]) step("threshold", ws[i], 1'b0);
    endtask

    task automatic test_missing();
        step("missing_head", 0, 1'b0);
        step("missing_next_left", 500, 1'b0);
    endtask

    task automatic test_glitch();
        int ws [12] = '{100, 500, 100, 500, 300, 500, 100, 500, 300, 500, 300, 500};
        foreach (ws[i]) step("glitch", ws[i], 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            step("random", ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(20, 400)), 1'b0);
    endtask

    task automatic test_enable_drop();
        int trigs;
        if (exp_sel == 1'b0) step("drop_pre", 150, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("drop", (i == 1) ? 150 : 300, 1'b1);
            trigs = 0;
            repeat (60) begin
                @(posedge clock);
                if (trig_head || trig_left) trigs++;
            end
            checks++;
            if (trigs !== 0) begin
                errors++;
                $display("FAIL drop_idle_trig: got %0d trigger cycles want 0", trigs);
            end
            checks++;
            if (n_valid !== exp_valid) begin
                errors++;
                $display("FAIL drop_valid_count: got %0d want %0d", n_valid, exp_valid);
            end
            checks++;
            if ({head, left} !== {exp_out[0], exp_out[1]}) begin
                errors++;
                $display("FAIL drop_head_left: got %0b%0b want %0b%0b", head, left, exp_out[0], exp_out[1]);
            end
            if (i < 2) enable = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_wall_ahead();
        test_threshold();
        test_missing();
        test_glitch();
        test_random();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
